// File: rtl/csel_sub_seq.sv
// csel_sub_seq: multi-cycle chunked carry-select subtractor, {bout,D} = A - B - bin; define CSEL_SUB_FLAGS_EN to add zero/ovf flag outputs
module csel_sub_seq #(
    parameter int WIDTH = 19,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             bout
`ifdef CSEL_SUB_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);

    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int CW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, d_q, d_d;
    logic             brw_q, brw_d, bout_q, bout_d;
    logic [CHUNK-1:0] a_k, b_k;
    logic [CHUNK:0]   diff0, diff1, sel;
    logic [WIDTH-1:0] chunk_mask, chunk_ins;

    // Current chunk of each operand; the final partial chunk is zero-padded by the shift.
    assign a_k = CHUNK'(a_q >> (32'(cnt_q) * CHUNK));
    assign b_k = CHUNK'(b_q >> (32'(cnt_q) * CHUNK));
    // Both borrow-in cases are formed up front; MSB of each is the chunk borrow-out.
    assign diff0 = {1'b0, a_k} - {1'b0, b_k};
    assign diff1 = {1'b0, a_k} - {1'b0, b_k} - (CHUNK + 1)'(1);
    assign sel   = brw_q ? diff1 : diff0;
    // Bits of the last chunk that fall beyond WIDTH drop out of the shift.
    assign chunk_mask = WIDTH'({CHUNK{1'b1}}) << (32'(cnt_q) * CHUNK);
    assign chunk_ins  = WIDTH'(sel[CHUNK-1:0]) << (32'(cnt_q) * CHUNK);

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign D         = d_q;
    assign bout      = bout_q;

    // Next-state: latch operands in IDLE, one chunk per RUN cycle, hold result in DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        brw_d   = brw_q;
        d_d     = d_q;
        bout_d  = bout_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = A;
                b_d     = B;
                brw_d   = bin;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                d_d   = (d_q & ~chunk_mask) | chunk_ins;
                brw_d = sel[CHUNK];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    bout_d  = sel[CHUNK];
                    state_d = DONE;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            brw_q   <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            brw_q   <= brw_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
        end
    end

`ifdef CSEL_SUB_FLAGS_EN
    logic zero_q, ovf_q;

    assign zero = zero_q;
    assign ovf  = ovf_q;

    // Flags are taken from the completed difference on the step into DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (state_q == RUN && cnt_q == LAST) begin
            zero_q <= d_d == '0;
            ovf_q  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_d[WIDTH-1] != a_q[WIDTH-1]);
        end
    end
`endif

endmodule
